phy_rx_link_ctrl: RTL and testbench

Receive-side link controller between the serial-to-parallel converter and the four lane buffers of the PHY RX path. It monitors the recovered 8-bit symbol stream and acquires lock on a run of COM symbols. Once locked, it schedules data bytes round-robin onto four lanes, honouring per-lane ready. It drives the active indication toward the parallel-to-serial side and drops lock when the valid stream goes silent.

---
 rtl/phy_rx_link_ctrl.sv | 146 ++++++++++++++
 tb/tb_phy_rx_link_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_link_ctrl.sv
// Receive-side link controller: acquires lock on a run of COM symbols, then deals
// data bytes round-robin onto four lanes and drops lock when valid goes silent.
module phy_rx_link_ctrl #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter logic [7:0] IDL_SYMBOL = 8'h7C,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 8
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic [3:0] lane_ready,
  output logic [7:0] data_out,
  output logic [3:0] lane_valid,
  output logic       active_to_PS,
  output logic [1:0] state,
  output logic [7:0] drop_count,
  output logic       lock_lost
);

  // state   | meaning
  // IDLE    | post-reset, moves to SEARCH on the next edge
  // SEARCH  | counting consecutive valid COM symbols, no dispatch
  // ACTIVE  | locked, dispatching data bytes round-robin, watching for gaps
  // ILLEGAL | unreachable encoding, recovers to IDLE with outputs cleared
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SEARCH  = 2'b01,
    ST_ACTIVE  = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
  localparam logic [7:0] LOSS_C = 8'(LOSS_COUNT);

  state_t     state_q, state_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [1:0] lane_ptr_q, lane_ptr_d;
  logic [7:0] data_q, data_d;
  logic [3:0] lane_valid_q, lane_valid_d;
  logic       active_q, active_d;
  logic [7:0] drop_q, drop_d;
  logic       lost_q, lost_d;

  always_comb begin
    state_d      = state_q;
    com_cnt_d    = com_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    lane_ptr_d   = lane_ptr_q;
    data_d       = data_q;
    lane_valid_d = 4'b0000;
    drop_d       = drop_q;
    lost_d       = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_SEARCH;

      ST_SEARCH: begin
        if (valid_in) begin
          if (data_in == COM_SYMBOL) begin
            if (com_cnt_q + 4'd1 == LOCK_C) begin
              state_d    = ST_ACTIVE;
              com_cnt_d  = 4'd0;
              lane_ptr_d = 2'd0;
              gap_cnt_d  = 8'd0;
            end else begin
              com_cnt_d = com_cnt_q + 4'd1;
            end
          end else begin
            com_cnt_d = 4'd0;
          end
        end
      end

      ST_ACTIVE: begin
        if (valid_in) begin
          gap_cnt_d = 8'd0;
          if (data_in == COM_SYMBOL) begin
            lane_ptr_d = 2'd0;
          end else if (data_in != IDL_SYMBOL) begin
            // The pointer advances even on a drop so bytes keep their lane mapping.
            if (lane_ready[lane_ptr_q]) begin
              data_d       = data_in;
              lane_valid_d = 4'b0001 << lane_ptr_q;
            end else if (drop_q != 8'hFF) begin
              drop_d = drop_q + 8'd1;
            end
            lane_ptr_d = lane_ptr_q + 2'd1;
          end
        end else if (gap_cnt_q + 8'd1 == LOSS_C) begin
          state_d   = ST_SEARCH;
          lost_d    = 1'b1;
          com_cnt_d = 4'd0;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        com_cnt_d  = 4'd0;
        gap_cnt_d  = 8'd0;
        lane_ptr_d = 2'd0;
        data_d     = 8'd0;
        drop_d     = 8'd0;
      end
    endcase

    active_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      com_cnt_q    <= 4'd0;
      gap_cnt_q    <= 8'd0;
      lane_ptr_q   <= 2'd0;
      data_q       <= 8'd0;
      lane_valid_q <= 4'b0000;
      active_q     <= 1'b0;
      drop_q       <= 8'd0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      com_cnt_q    <= com_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      lane_ptr_q   <= lane_ptr_d;
      data_q       <= data_d;
      lane_valid_q <= lane_valid_d;
      active_q     <= active_d;
      drop_q       <= drop_d;
      lost_q       <= lost_d;
    end
  end

  assign state        = state_q;
  assign data_out     = data_q;
  assign lane_valid   = lane_valid_q;
  assign active_to_PS = active_q;
  assign drop_count   = drop_q;
  assign lock_lost    = lost_q;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Self-checking bench for phy_rx_link_ctrl: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model of the link rules.
module tb_phy_rx_link_ctrl;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDL  = 8'h7C;
  localparam int         LOCK = 4;
  localparam int         LOSS = 8;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [3:0] lane_ready = 4'h0;
  logic [7:0] data_out;
  logic [3:0] lane_valid;
  logic       active_to_PS;
  logic [1:0] state;
  logic [7:0] drop_count;
  logic       lock_lost;

  phy_rx_link_ctrl #(
    .COM_SYMBOL(COM),
    .IDL_SYMBOL(IDL),
    .LOCK_COUNT(LOCK),
    .LOSS_COUNT(LOSS)
  ) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .lane_ready  (lane_ready),
    .data_out    (data_out),
    .lane_valid  (lane_valid),
    .active_to_PS(active_to_PS),
    .state       (state),
    .drop_count  (drop_count),
    .lock_lost   (lock_lost)
  );

  always #5 clk_4f = ~clk_4f;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0 idle, 1 hunting for lock, 2 locked.
  int         m_mode, m_run, m_gap, m_lane, m_drops;
  logic [7:0] m_data;
  logic [3:0] m_strobe;
  logic       m_lost;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [7:0] d,
                            input logic [3:0] rdy);
    if (!rst) begin
      m_mode = 0; m_run = 0; m_gap = 0; m_lane = 0; m_drops = 0;
      m_data = 8'h00; m_strobe = 4'h0; m_lost = 1'b0;
      return;
    end
    m_strobe = 4'h0;
    m_lost   = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (v) begin
        m_run = (d == COM) ? m_run + 1 : 0;
        if (m_run == LOCK) begin
          m_mode = 2; m_run = 0; m_lane = 0; m_gap = 0;
        end
      end
    end else begin
      if (!v) begin
        m_gap++;
        if (m_gap == LOSS) begin
          m_mode = 1; m_lost = 1'b1; m_run = 0; m_gap = 0;
        end
      end else begin
        m_gap = 0;
        if (d == COM) m_lane = 0;
        else if (d != IDL) begin
          if (rdy[m_lane]) begin
            m_data   = d;
            m_strobe = 4'h0;
            m_strobe[m_lane] = 1'b1;
          end else begin
            m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
          end
          m_lane = (m_lane + 1) % 4;
        end
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic v, input logic [7:0] d,
                       input logic [3:0] rdy);
    logic [1:0] exp_state;
    reset = rst; valid_in = v; data_in = d; lane_ready = rdy;
    @(posedge clk_4f);
    model_step(rst, v, d, rdy);
    #1;
    exp_state = 2'(m_mode);
    check("state", 32'(state), 32'(exp_state));
    check("active_to_PS", 32'(active_to_PS), 32'(m_mode == 2));
    check("lane_valid", 32'(lane_valid), 32'(m_strobe));
    check("data_out", 32'(data_out), 32'(m_data));
    check("drop_count", 32'(drop_count), 32'(m_drops));
    check("lock_lost", 32'(lock_lost), 32'(m_lost));
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] rdy);
    cycle(1'b1, 1'b1, d, rdy);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 4'hF);
  endtask

  task automatic acquire();
    for (int i = 0; i < LOCK; i++) send(COM, 4'hF);
  endtask

  initial begin
    int n;
    int r;
    logic [7:0] b;
    m_mode = 0; m_run = 0; m_gap = 0; m_lane = 0; m_drops = 0;
    m_data = 8'h00; m_strobe = 4'h0; m_lost = 1'b0;

    // Reset and acquisition
    cycle(1'b0, 1'b0, 8'h00, 4'h0);
    cycle(1'b0, 1'b1, COM, 4'hF);
    check("rst_state_const", 32'(state), 32'd0);
    gap(1);
    acquire();
    check("locked_const", 32'(state), 32'd2);

    // Round-robin with wrap, COM realign, IDL ignored
    send(8'h11, 4'hF); send(8'h22, 4'hF); send(8'h33, 4'hF);
    send(8'h44, 4'hF); send(8'h55, 4'hF);
    check("wrap_lane_const", 32'(lane_valid), 32'h1);
    send(COM, 4'hF); send(8'h66, 4'hF);
    check("com_realign_const", 32'(lane_valid), 32'h1);
    send(IDL, 4'hF); send(8'h77, 4'hF);
    check("idl_skip_const", 32'(lane_valid), 32'h2);

    // Backpressure
    send(COM, 4'hF);
    send(8'hA1, 4'b1101); send(8'hA2, 4'b1101); send(8'hA3, 4'b1101);
    check("bp_lane2_const", 32'(lane_valid), 32'h4);
    check("bp_drop_const", 32'(drop_count), 32'd1);

    // Gaps just short of the loss threshold, then a real loss
    gap(7); send(8'h5A, 4'hF);
    gap(7); send(IDL, 4'hF);
    gap(8);
    check("loss_const", 32'(state), 32'd1);

    // Broken lock run
    send(COM, 4'hF); send(COM, 4'hF); send(8'h55, 4'hF);
    send(COM, 4'hF); send(COM, 4'hF); send(COM, 4'hF);
    check("broken_hold_const", 32'(state), 32'd1);
    send(COM, 4'hF);
    check("broken_lock_const", 32'(state), 32'd2);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) send(8'(i % 100), 4'h0);
    check("drop_sat_const", 32'(drop_count), 32'd255);

    // Reset mid-dispatch
    send(8'h42, 4'hF);
    cycle(1'b0, 1'b1, 8'h43, 4'hF);
    check("mid_rst_lv_const", 32'(lane_valid), 32'h0);
    check("mid_rst_drop_const", 32'(drop_count), 32'd0);
    gap(1);

    // Randomized episodes
    for (int ep = 0; ep < 120; ep++) begin
      for (int i = 0; i < LOCK + 1; i++)
        send(($urandom_range(0, 19) == 0) ? 8'h3C : COM, 4'(($urandom)));
      n = $urandom_range(10, 50);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 99);
        b = 8'($urandom);
        if (r < 10) b = COM;
        else if (r < 20) b = IDL;
        cycle(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
              ($urandom_range(0, 4) != 0), b, 4'($urandom));
      end
      gap($urandom_range(4, 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
